// File: rtl/pll_seq_pkg.sv
// Shared types and default tuning constants for the PLL lock sequencer.
package pll_seq_pkg;

  // Sequencer state codes; the encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESET    = 3'd1,
    ST_LINK_WAIT = 3'd2,
    ST_ACQUIRE   = 3'd3,
    ST_LOCKED    = 3'd4,
    ST_RETRY     = 3'd5,
    ST_FAIL      = 3'd6
  } pll_state_e;

  localparam int DEF_ERR_W         = 32;
  localparam int DEF_PRESET_CYCLES = 4096;
  localparam int DEF_LINK_EDGES    = 4;
  localparam int DEF_LINK_TIMEOUT  = 16384;
  localparam int DEF_LOCK_TOL      = 50;
  localparam int DEF_LOCK_COUNT    = 8;
  localparam int DEF_UNLOCK_TOL    = 200;
  localparam int DEF_UNLOCK_COUNT  = 3;
  localparam int DEF_ACQ_TIMEOUT   = 262144;
  localparam int DEF_MAX_RETRY     = 3;

  // Largest of three limits; sizes the shared per-state cycle timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_link_edge_sync.sv
// Two-flop synchroniser for an asynchronous input followed by a registered
// rising-edge pulse. The pulse appears three clk edges after the pin is sampled.
module pll_link_edge_sync (
  input  logic clk,
  input  logic nrst,
  input  logic async_in,
  output logic rise
);

  logic sync_q1;
  logic sync_q2;
  logic prev_q;

  // Synchronise the pin, remember the previous level, and pulse on 0->1.
  always_ff @(posedge clk) begin
    // NOTE: registers take <= so every flop samples the pre-edge value of its
    // neighbour; with = the chain would collapse into a single stage.
    if (nrst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      prev_q  <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_q1 <= async_in;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
      rise    <= sync_q2 & ~prev_q;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings the SWIPT PLL from power-up to lock: open-loop preset, reference
// qualification, closed-loop acquisition, lock monitoring and bounded retry.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int ERR_W         = DEF_ERR_W,
  parameter int PRESET_CYCLES = DEF_PRESET_CYCLES,
  parameter int LINK_EDGES    = DEF_LINK_EDGES,
  parameter int LINK_TIMEOUT  = DEF_LINK_TIMEOUT,
  parameter int LOCK_TOL      = DEF_LOCK_TOL,
  parameter int LOCK_COUNT    = DEF_LOCK_COUNT,
  parameter int UNLOCK_TOL    = DEF_UNLOCK_TOL,
  parameter int UNLOCK_COUNT  = DEF_UNLOCK_COUNT,
  parameter int ACQ_TIMEOUT   = DEF_ACQ_TIMEOUT,
  parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             swipt_alive,
  input  logic             link,
  input  logic [ERR_W-1:0] phase_err,
  input  logic             phase_err_valid,
  output logic             freq_rdy,
  output logic             pll_en,
  output logic             locked,
  output logic             lock_lost,
  output logic             fail,
  output logic [1:0]       retry_cnt,
  output logic [2:0]       state
);

  // One timer serves every timed state, so it is sized for the longest limit.
  localparam int TMR_MAXV = max3(PRESET_CYCLES, LINK_TIMEOUT, ACQ_TIMEOUT);
  localparam int TMR_W    = $clog2(TMR_MAXV + 1);
  localparam int EDGE_W   = $clog2(LINK_EDGES + 1);
  localparam int LOCK_W   = $clog2(LOCK_COUNT + 1);
  localparam int UNLK_W   = $clog2(UNLOCK_COUNT + 1);

  localparam logic [TMR_W-1:0]  TMR_SAT     = TMR_W'(TMR_MAXV);
  localparam logic [TMR_W-1:0]  PRESET_LAST = TMR_W'(PRESET_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LINK_LAST   = TMR_W'(LINK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  ACQ_LAST    = TMR_W'(ACQ_TIMEOUT - 1);
  localparam logic [EDGE_W-1:0] EDGE_SAT    = EDGE_W'(LINK_EDGES);
  localparam logic [EDGE_W-1:0] EDGE_LAST   = EDGE_W'(LINK_EDGES - 1);
  localparam logic [LOCK_W-1:0] LOCK_SAT    = LOCK_W'(LOCK_COUNT);
  localparam logic [LOCK_W-1:0] LOCK_LAST   = LOCK_W'(LOCK_COUNT - 1);
  localparam logic [UNLK_W-1:0] UNLK_SAT    = UNLK_W'(UNLOCK_COUNT);
  localparam logic [UNLK_W-1:0] UNLK_LAST   = UNLK_W'(UNLOCK_COUNT - 1);
  localparam logic [ERR_W-1:0]  LOCK_TOL_V   = ERR_W'(LOCK_TOL);
  localparam logic [ERR_W-1:0]  UNLOCK_TOL_V = ERR_W'(UNLOCK_TOL);

  pll_state_e        state_q;
  pll_state_e        state_d;
  logic              link_rise;
  logic [TMR_W-1:0]  tmr_q;
  logic [EDGE_W-1:0] edge_cnt_q;
  logic [LOCK_W-1:0] lock_cnt_q;
  logic [UNLK_W-1:0] unlk_cnt_q;

  logic in_lock_smp;
  logic out_lock_smp;
  logic edge_done;
  logic lock_done;
  logic unlock_done;

  pll_link_edge_sync u_link_sync (
    .clk      (clk),
    .nrst     (nrst),
    .async_in (link),
    .rise     (link_rise)
  );

  assign in_lock_smp  = phase_err_valid && (phase_err <= LOCK_TOL_V);
  assign out_lock_smp = phase_err_valid && (phase_err >  UNLOCK_TOL_V);
  assign edge_done    = link_rise    && (edge_cnt_q == EDGE_LAST);
  assign lock_done    = in_lock_smp  && (lock_cnt_q == LOCK_LAST);
  assign unlock_done  = out_lock_smp && (unlk_cnt_q == UNLK_LAST);
  assign state        = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (nrst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state: power loss beats everything; completion beats timeout.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch appears.
    state_d = state_q;
    if (!swipt_alive) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_PRESET;
        ST_PRESET:    if (tmr_q == PRESET_LAST) state_d = ST_LINK_WAIT;
        ST_LINK_WAIT: begin
          if (edge_done)               state_d = ST_ACQUIRE;
          else if (tmr_q == LINK_LAST) state_d = ST_RETRY;
        end
        ST_ACQUIRE: begin
          if (lock_done)              state_d = ST_LOCKED;
          else if (tmr_q == ACQ_LAST) state_d = ST_RETRY;
        end
        ST_LOCKED:    if (unlock_done) state_d = ST_RETRY;
        ST_RETRY:     state_d = (int'(retry_cnt) < MAX_RETRY) ? ST_PRESET : ST_FAIL;
        ST_FAIL:      state_d = ST_FAIL;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Per-state counters: cleared on every state change, saturating otherwise.
  always_ff @(posedge clk) begin
    if (nrst || (state_d != state_q)) begin
      tmr_q      <= '0;
      edge_cnt_q <= '0;
      lock_cnt_q <= '0;
      unlk_cnt_q <= '0;
    end else begin
      if (tmr_q != TMR_SAT) tmr_q <= tmr_q + TMR_W'(1);
      if ((state_q == ST_LINK_WAIT) && link_rise && (edge_cnt_q != EDGE_SAT))
        edge_cnt_q <= edge_cnt_q + EDGE_W'(1);
      if ((state_q == ST_ACQUIRE) && phase_err_valid) begin
        if (!in_lock_smp)               lock_cnt_q <= '0;
        else if (lock_cnt_q != LOCK_SAT) lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
      end
      if ((state_q == ST_LOCKED) && phase_err_valid) begin
        if (!out_lock_smp)               unlk_cnt_q <= '0;
        else if (unlk_cnt_q != UNLK_SAT) unlk_cnt_q <= unlk_cnt_q + UNLK_W'(1);
      end
    end
  end

  // Registered outputs decoded from the state being entered on this edge.
  always_ff @(posedge clk) begin
    if (nrst) begin
      freq_rdy  <= 1'b0;
      pll_en    <= 1'b0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= 2'd0;
    end else begin
      freq_rdy  <= (state_d == ST_PRESET) || (state_d == ST_LINK_WAIT);
      pll_en    <= state_d inside {ST_PRESET, ST_LINK_WAIT, ST_ACQUIRE, ST_LOCKED};
      locked    <= (state_d == ST_LOCKED);
      lock_lost <= (state_q == ST_LOCKED) && (state_d == ST_RETRY);
      // fail survives the drop to IDLE and clears only when the link re-arms.
      if (state_d == ST_FAIL)
        fail <= 1'b1;
      else if ((state_q == ST_IDLE) && (state_d == ST_PRESET))
        fail <= 1'b0;
      if ((state_d == ST_IDLE) || (state_q == ST_IDLE))
        retry_cnt <= 2'd0;
      else if ((state_q == ST_RETRY) && (state_d == ST_PRESET) && (retry_cnt != 2'd3))
        retry_cnt <= retry_cnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomised and directed bench for pll_lock_sequencer with a cycle-level
// behavioural model and literal spot checks on the key sequences.
module tb_pll_lock_sequencer;

  localparam int P_ERR_W   = 32;
  localparam int P_PRESET  = 16;
  localparam int P_EDGES   = 2;
  localparam int P_LTO     = 64;
  localparam int P_LTOL    = 50;
  localparam int P_LOCKC   = 4;
  localparam int P_UTOL    = 200;
  localparam int P_UNLC    = 2;
  localparam int P_ATO     = 200;
  localparam int P_MAXR    = 1;

  localparam int S_IDLE = 0, S_PRESET = 1, S_LWAIT = 2, S_ACQ = 3;
  localparam int S_LOCK = 4, S_RETRY = 5, S_FAIL = 6;

  logic               clk;
  logic               nrst;
  logic               swipt_alive;
  logic               link;
  logic [P_ERR_W-1:0] phase_err;
  logic               phase_err_valid;
  logic               freq_rdy;
  logic               pll_en;
  logic               locked;
  logic               lock_lost;
  logic               fail;
  logic [1:0]         retry_cnt;
  logic [2:0]         state;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int link_mode = 1;

  int noisy [7] = '{10, 10, 60, 10, 10, 10, 10};
  int bnd   [4] = '{50, 51, 200, 201};

  pll_lock_sequencer #(
    .ERR_W        (P_ERR_W),
    .PRESET_CYCLES(P_PRESET),
    .LINK_EDGES   (P_EDGES),
    .LINK_TIMEOUT (P_LTO),
    .LOCK_TOL     (P_LTOL),
    .LOCK_COUNT   (P_LOCKC),
    .UNLOCK_TOL   (P_UTOL),
    .UNLOCK_COUNT (P_UNLC),
    .ACQ_TIMEOUT  (P_ATO),
    .MAX_RETRY    (P_MAXR)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .swipt_alive    (swipt_alive),
    .link           (link),
    .phase_err      (phase_err),
    .phase_err_valid(phase_err_valid),
    .freq_rdy       (freq_rdy),
    .pll_en         (pll_en),
    .locked         (locked),
    .lock_lost      (lock_lost),
    .fail           (fail),
    .retry_cnt      (retry_cnt),
    .state          (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Tracks which phase the sequencer should be in, how long it has been
  // there, and the running sample streak; link edges are seen 3 cycles late.
  int m_state = S_IDLE;
  int m_age   = 0;
  int m_edges = 0;
  int m_run   = 0;
  int m_retry = 0;
  bit m_fail  = 1'b0;
  bit m_lost  = 1'b0;
  bit lh [4];

  task automatic model_step();
    int nxt;
    bit rise;
    if (nrst) begin
      m_state = S_IDLE; m_age = 0; m_edges = 0; m_run = 0;
      m_retry = 0; m_fail = 1'b0; m_lost = 1'b0;
      for (int i = 0; i < 4; i++) lh[i] = 1'b0;
      return;
    end
    rise  = lh[2] & ~lh[3];
    lh[3] = lh[2]; lh[2] = lh[1]; lh[1] = lh[0]; lh[0] = link;
    nxt    = m_state;
    m_lost = 1'b0;
    if (!swipt_alive) nxt = S_IDLE;
    else begin
      case (m_state)
        S_IDLE:   nxt = S_PRESET;
        S_PRESET: if (m_age + 1 == P_PRESET) nxt = S_LWAIT;
        S_LWAIT: begin
          if (m_edges + int'(rise) == P_EDGES) nxt = S_ACQ;
          else if (m_age + 1 == P_LTO)     nxt = S_RETRY;
        end
        S_ACQ: begin
          if (phase_err_valid) m_run = (phase_err <= P_LTOL) ? m_run + 1 : 0;
          if (m_run == P_LOCKC)       nxt = S_LOCK;
          else if (m_age + 1 == P_ATO) nxt = S_RETRY;
        end
        S_LOCK: begin
          if (phase_err_valid) m_run = (phase_err > P_UTOL) ? m_run + 1 : 0;
          if (m_run == P_UNLC) begin nxt = S_RETRY; m_lost = 1'b1; end
        end
        S_RETRY: nxt = (m_retry < P_MAXR) ? S_PRESET : S_FAIL;
        default: nxt = m_state;
      endcase
    end
    if (nxt == S_IDLE) m_retry = 0;
    if (m_state == S_IDLE && nxt == S_PRESET) begin m_retry = 0; m_fail = 1'b0; end
    if (m_state == S_RETRY && nxt == S_PRESET && m_retry < 3) m_retry++;
    if (nxt == S_FAIL) m_fail = 1'b1;
    if (nxt != m_state) begin
      m_age = 0; m_edges = 0; m_run = 0;
    end else begin
      m_age++;
      if (m_state == S_LWAIT) m_edges += int'(rise);
    end
    m_state = nxt;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  // Compare every output against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("state",     state,     m_state);
    check("freq_rdy",  freq_rdy,  (m_state == S_PRESET || m_state == S_LWAIT));
    check("pll_en",    pll_en,    (m_state >= S_PRESET && m_state <= S_LOCK));
    check("locked",    locked,    (m_state == S_LOCK));
    check("lock_lost", lock_lost, m_lost);
    check("fail",      fail,      m_fail);
    check("retry_cnt", retry_cnt, m_retry);
  end

  // ---------------- stimulus ----------------
  // Link source: held low, a square wave of period 20, or random per cycle.
  initial begin
    int lc;
    lc   = 0;
    link = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (link_mode)
        0: link = 1'b0;
        1: begin
          lc++;
          if (lc >= 10) begin lc = 0; link = ~link; end
        end
        default: link = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_sample(input int v);
    phase_err       = P_ERR_W'(v);
    phase_err_valid = 1'b1;
    tick();
    phase_err_valid = 1'b0;
    phase_err       = $urandom;
  endtask

  task automatic wait_model(input int code, input int budget, input string name);
    int n;
    n = 0;
    while (m_state != code && n < budget) begin tick(); n++; end
    check(name, state, code);
  endtask

  initial begin
    int n;
    int k;
    nrst = 1'b1; swipt_alive = 1'b1; phase_err_valid = 1'b0; phase_err = '0;
    link_mode = 1;
    tick();
    check("rst_state", state, S_IDLE);
    check("rst_freq_rdy", freq_rdy, 0);
    check("rst_pll_en", pll_en, 0);
    check("rst_locked", locked, 0);
    check("rst_lock_lost", lock_lost, 0);
    check("rst_fail", fail, 0);
    check("rst_retry_cnt", retry_cnt, 0);
    nrst = 1'b0;

    // Nominal acquisition.
    tick();
    check("preset_entry", state, S_PRESET);
    check("preset_freq_rdy", freq_rdy, 1);
    check("preset_pll_en", pll_en, 1);
    n = 0;
    while (state == 3'(S_PRESET) && n < 100) begin n++; tick(); end
    check("preset_length", n, P_PRESET);
    check("lwait_freq_rdy", freq_rdy, 1);
    wait_model(S_ACQ, 100, "reach_acquire");
    check("acq_freq_rdy", freq_rdy, 0);
    check("acq_pll_en", pll_en, 1);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      if (k == 0) begin
        send_sample(10);
        if (locked) k = i; else idle(19);
      end
    end
    check("nominal_lock_sample", k, 4);
    check("model_locked", m_state, S_LOCK);

    // Isolated out-of-lock samples keep lock; two in a row lose it.
    send_sample(250); check("hold1_state", state, S_LOCK); idle(5);
    send_sample(100); idle(5);
    send_sample(250); check("hold3_state", state, S_LOCK); check("hold3_locked", locked, 1); idle(5);
    send_sample(10);  idle(5);
    send_sample(250); check("loss1_locked", locked, 1); idle(5);
    send_sample(250);
    check("loss_pulse", lock_lost, 1);
    check("loss_locked", locked, 0);
    check("loss_state", state, S_RETRY);
    check("loss_pll_en", pll_en, 0);
    tick();
    check("loss_pulse_end", lock_lost, 0);
    check("loss_retry_cnt", retry_cnt, 1);
    check("loss_to_preset", state, S_PRESET);

    // Power drop during acquisition.
    wait_model(S_ACQ, 200, "reach_acquire2");
    send_sample(10); idle(3);
    swipt_alive = 1'b0; tick();
    check("drop_state", state, S_IDLE);
    check("drop_freq_rdy", freq_rdy, 0);
    check("drop_pll_en", pll_en, 0);
    swipt_alive = 1'b1; tick();
    check("rearm_state", state, S_PRESET);
    check("rearm_retry_cnt", retry_cnt, 0);

    // Noisy acquisition: the 60 restarts the streak.
    wait_model(S_ACQ, 200, "reach_acquire3");
    k = 0;
    for (int i = 0; i < 7; i++) begin
      send_sample(noisy[i]);
      if (locked && k == 0) k = i + 1;
      idle(19);
    end
    check("noisy_lock_sample", k, 7);

    // Reset lands on the same edge as a pending loss of lock.
    send_sample(250); idle(2);
    phase_err = 250; phase_err_valid = 1'b1; nrst = 1'b1;
    tick();
    phase_err_valid = 1'b0; nrst = 1'b0;
    check("midrst_state", state, S_IDLE);
    check("midrst_lock_lost", lock_lost, 0);
    check("midrst_locked", locked, 0);
    check("midrst_pll_en", pll_en, 0);

    // No reference: two link timeouts exhaust the single retry.
    link_mode = 0; swipt_alive = 1'b0; tick(); swipt_alive = 1'b1;
    wait_model(S_LWAIT, 40, "reach_lwait_noref");
    n = 0;
    while (state == 3'(S_LWAIT) && n < 200) begin n++; tick(); end
    check("lwait_timeout_len", n, P_LTO);
    check("noref_retry", state, S_RETRY);
    wait_model(S_FAIL, 200, "reach_fail");
    check("fail_flag", fail, 1);
    check("fail_pll_en", pll_en, 0);
    check("fail_retry_cnt", retry_cnt, 1);
    idle(10);
    check("fail_held", state, S_FAIL);
    swipt_alive = 1'b0; tick();
    check("fail_idle_state", state, S_IDLE);
    check("fail_sticky", fail, 1);
    swipt_alive = 1'b1; tick();
    check("fail_cleared", fail, 0);
    check("fail_rearm_state", state, S_PRESET);

    // Randomised traffic around the tolerance boundaries.
    for (int c = 0; c < 5000; c++) begin
      if (c % 250 == 0) link_mode = $urandom_range(0, 2);
      nrst = ($urandom_range(0, 799) == 0);
      if (swipt_alive) swipt_alive = ($urandom_range(0, 299) != 0);
      else             swipt_alive = ($urandom_range(0, 9) == 0);
      phase_err_valid = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 7))
        0, 1, 2, 3: phase_err = $urandom_range(0, P_LTOL);
        4:          phase_err = P_ERR_W'(bnd[$urandom_range(0, 3)]);
        5:          phase_err = $urandom_range(P_LTOL + 1, P_UTOL);
        6:          phase_err = $urandom_range(P_UTOL + 1, 400);
        default:    phase_err = $urandom;
      endcase
      tick();
    end
    nrst = 1'b0;
    phase_err_valid = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences the SWIPT PLL from power-up to lock.
- Holds the VCO at its free-running start frequency via freq_rdy, waits for a live reference on link, then releases the loop to closed-loop tracking.
- Qualifies lock from per-reference-period phase-error samples, detects loss of lock, and retries a bounded number of times before reporting failure.
- Sits between the SWIPT power/link supervisor and the PLL core.

Parameters:
- ERR_W, 32, width of phase_err sample.
- PRESET_CYCLES, 4096, clk cycles freq_rdy is held high before looking for the reference.
- LINK_EDGES, 4, rising link edges required to accept the reference.
- LINK_TIMEOUT, 16384, clk cycles allowed in LINK_WAIT.
- LOCK_TOL, 50, phase_err at or below this value counts as an in-lock sample.
- LOCK_COUNT, 8, consecutive in-lock samples needed to declare lock.
- UNLOCK_TOL, 200, phase_err above this value counts as an out-of-lock sample.
- UNLOCK_COUNT, 3, consecutive out-of-lock samples needed to declare loss of lock.
- ACQ_TIMEOUT, 262144, clk cycles allowed in ACQUIRE.
- MAX_RETRY, 3, retries allowed before FAIL.

Ports:
- clk  in  1  system clock (100 MHz).
- nrst  in  1  reset, synchronous, active-high.
- swipt_alive  in  1  power link present; synchronous level.
- link  in  1  asynchronous reference from the receiver; synchronised internally.
- phase_err  in  ERR_W  unsigned phase-error magnitude, one sample per reference period.
- phase_err_valid  in  1  one-cycle strobe qualifying phase_err.
- freq_rdy  out  1  1 = PLL forced to f0 open-loop; 0 = closed loop.
- pll_en  out  1  PLL core enable.
- locked  out  1  lock qualified.
- lock_lost  out  1  one-cycle pulse on loss of lock.
- fail  out  1  sticky: retries exhausted.
- retry_cnt  out  2  retries used, saturating.
- state  out  3  current state code, for debug.

Behaviour:
- Reset: clk is the only clock. When nrst=1 at a clk edge, all outputs and counters clear: state=IDLE, freq_rdy=0, pll_en=0, locked=0, lock_lost=0, fail=0, retry_cnt=0.
- Outputs are registered and change on the same edge as the state transition.
- Link input path: 2-FF synchroniser, then a rising-edge detector. Edge detection lags the pin by 3 cycles.
- IDLE: all outputs 0. swipt_alive=1 -> PRESET.
- PRESET: pll_en=1, freq_rdy=1, locked=0. Counts PRESET_CYCLES, then -> LINK_WAIT.
- LINK_WAIT: freq_rdy=1. Counts link rising edges.
  - LINK_EDGES edges -> ACQUIRE.
  - LINK_TIMEOUT reached with fewer edges -> RETRY.
- ACQUIRE: freq_rdy=0.
  - On each phase_err_valid: phase_err<=LOCK_TOL increments the in-lock count; any other value clears it.
  - Count reaching LOCK_COUNT -> LOCKED, with locked=1 on the same edge.
  - ACQ_TIMEOUT reached -> RETRY.
- LOCKED: freq_rdy=0, locked=1.
  - On each phase_err_valid: phase_err>UNLOCK_TOL increments the out-of-lock count; any other value clears it.
  - Count reaching UNLOCK_COUNT -> RETRY, with lock_lost=1 for exactly one cycle and locked=0.
- RETRY (1 cycle): pll_en=0.
  - retry_cnt<MAX_RETRY -> retry_cnt+1, -> PRESET.
  - Otherwise -> FAIL.
- FAIL: pll_en=0, fail=1. Held until swipt_alive=0 or reset.
- swipt_alive=0 in any state: -> IDLE next edge with all outputs 0. The only exception is fail, which is sticky until nrst or until swipt_alive re-rises from IDLE. retry_cnt clears on IDLE->PRESET.
- Priority within one cycle: nrst > swipt_alive=0 > count/timeout transitions.
- Same-cycle tie: phase_err_valid completing LOCK_COUNT in the same cycle ACQ_TIMEOUT expires -> LOCKED.
- Counters:
  - Each counter is sized $clog2(param+1) and clears on every state entry.
  - Sample counters saturate and never wrap.
  - phase_err_valid outside ACQUIRE/LOCKED is ignored.
- Comparisons are unsigned, full ERR_W width.

Decomposition:
- Package pll_seq_pkg holds the state enum (IDLE=0, PRESET=1, LINK_WAIT=2, ACQUIRE=3, LOCKED=4, RETRY=5, FAIL=6) and the default tolerance/count constants.
- One sub-module, pll_link_edge_sync: the 2-FF synchroniser plus rising-edge pulse, reusable for other link inputs.

Test Plan (sim parameters: PRESET_CYCLES=16, LINK_EDGES=2, LINK_TIMEOUT=64, LOCK_COUNT=4, UNLOCK_COUNT=2, ACQ_TIMEOUT=200, MAX_RETRY=1):
- Nominal acquisition: nrst pulse, swipt_alive=1, link toggling every 10 clk, phase_err=10 every 20 clk -> freq_rdy high 16 cycles, freq_rdy falls after the 2nd synchronised edge, locked=1 on the 4th valid sample.
- Noisy acquisition: in ACQUIRE send phase_err 10, 10, 60, 10, 10, 10, 10 -> locked rises only on the 7th sample (count restarts after 60).
- Loss of lock: from LOCKED send 250 then 250 -> lock_lost one-cycle pulse, locked=0, retry_cnt=1, state=PRESET two cycles later. Sending 250, 100, 250 instead -> stays LOCKED.
- No reference: link held 0 -> LINK_WAIT times out after 64 cycles -> RETRY -> PRESET; second timeout -> fail=1, pll_en=0, state=FAIL.
- Power drop: swipt_alive=0 mid-ACQUIRE -> next edge IDLE, freq_rdy=0, pll_en=0. Re-assert swipt_alive -> retry_cnt=0, PRESET.
- Reset mid-LOCKED: nrst=1 for one cycle -> all outputs 0 on that edge, including a pending lock_lost.
